ro_sweep_sequencer: RTL and testbench

Autonomous scheduler that sweeps the cell-mux page space and ring-oscillator tap selection without switch toggling.
- For each page in a programmed range and each of the 8 output taps:
  - drives page, input pattern and tap select,
  - holds the ring-oscillator timer enabled for a fixed window,
  - captures the 8-bit count and emits it as a tagged result over a valid/ready stream.
- Sits between the chip-level switch decoder and the cell_mux / ring_osc_timer pair.

---
 rtl/ro_sweep_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_ro_sweep_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_sweep_sequencer.sv
// Ring-oscillator sweep sequencer: walks a page range x 8 taps, times each tap, streams tagged counts.
// Optional peak tracker enabled by defining RO_SWEEP_PEAK_EN.
module ro_sweep_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int WINDOW_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  page_first,
  input  logic [5:0]  page_last,
  input  logic [5:0]  pattern,
  output logic [5:0]  cm_page,
  output logic [5:0]  cm_in,
  output logic        ro_en,
  output logic [2:0]  ro_sel,
  input  logic [7:0]  ro_count,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [16:0] res_data,
`ifdef RO_SWEEP_PEAK_EN
  output logic [7:0]  peak_count,
  output logic [8:0]  peak_tag,
`endif
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEASURE, S_CAPTURE, S_EMIT, S_NEXT
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         page_last_q, page_last_d;
  logic [5:0]         cm_page_d, cm_in_d;
  logic [2:0]         ro_sel_d;
  logic               ro_en_d, res_valid_d, busy_d, done_d;
  logic [16:0]        res_data_d;
`ifdef RO_SWEEP_PEAK_EN
  logic [7:0]         peak_count_d;
  logic [8:0]         peak_tag_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    page_last_d  = page_last_q;
    cm_page_d    = cm_page;
    cm_in_d      = cm_in;
    ro_sel_d     = ro_sel;
    ro_en_d      = ro_en;
    res_valid_d  = res_valid;
    res_data_d   = res_data;
    busy_d       = busy;
    done_d       = 1'b0;
`ifdef RO_SWEEP_PEAK_EN
    peak_count_d = peak_count;
    peak_tag_d   = peak_tag;
`endif
    // abort overrides every transition; mux-facing selects keep their last values
    if (abort) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      ro_en_d     = 1'b0;
      res_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            page_last_d  = page_last;
            cm_page_d    = page_first;
            cm_in_d      = pattern;
            ro_sel_d     = 3'd0;
            cnt_d        = '0;
            busy_d       = 1'b1;
            state_d      = S_SETTLE;
`ifdef RO_SWEEP_PEAK_EN
            peak_count_d = 8'd0;
            peak_tag_d   = 9'd0;
`endif
          end
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            ro_en_d = 1'b1;
            state_d = S_MEASURE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_MEASURE: begin
          if (cnt_q == WINDOW_LAST) begin
            cnt_d   = '0;
            ro_en_d = 1'b0;
            state_d = S_CAPTURE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          res_data_d  = {cm_page, ro_sel, ro_count};
          res_valid_d = 1'b1;
          state_d     = S_EMIT;
`ifdef RO_SWEEP_PEAK_EN
          if (ro_count > peak_count) begin
            peak_count_d = ro_count;
            peak_tag_d   = {cm_page, ro_sel};
          end
`endif
        end
        S_EMIT: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            state_d     = S_NEXT;
          end
        end
        S_NEXT: begin
          if (ro_sel != 3'd7) begin
            ro_sel_d = ro_sel + 3'd1;
            state_d  = S_SETTLE;
          end else if (cm_page != page_last_q) begin
            ro_sel_d  = 3'd0;
            cm_page_d = cm_page + 6'd1;
            state_d   = S_SETTLE;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      page_last_q <= '0;
      cm_page     <= '0;
      cm_in       <= '0;
      ro_sel      <= '0;
      ro_en       <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef RO_SWEEP_PEAK_EN
      peak_count  <= '0;
      peak_tag    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      page_last_q <= page_last_d;
      cm_page     <= cm_page_d;
      cm_in       <= cm_in_d;
      ro_sel      <= ro_sel_d;
      ro_en       <= ro_en_d;
      res_valid   <= res_valid_d;
      res_data    <= res_data_d;
      busy        <= busy_d;
      done        <= done_d;
`ifdef RO_SWEEP_PEAK_EN
      peak_count  <= peak_count_d;
      peak_tag    <= peak_tag_d;
`endif
    end
  end

endmodule

// File: tb/tb_ro_sweep_sequencer.sv
// Bench for ro_sweep_sequencer: transaction-level sweep model checked every cycle plus directed literals.
module tb_ro_sweep_sequencer;

  localparam int S = 4;
  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        res_ready = 1'b1;
  logic [5:0]  page_first = '0;
  logic [5:0]  page_last = '0;
  logic [5:0]  pattern = '0;
  logic [5:0]  cm_page, cm_in;
  logic        ro_en, res_valid, busy, done;
  logic [2:0]  ro_sel;
  logic [7:0]  ro_count;
  logic [16:0] res_data;
`ifdef RO_SWEEP_PEAK_EN
  logic [7:0]  peak_count;
  logic [8:0]  peak_tag;
`endif

  logic [7:0]  cnt_tab [64][8];

  assign ro_count = cnt_tab[cm_page][ro_sel];

  ro_sweep_sequencer #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .page_first(page_first), .page_last(page_last), .pattern(pattern),
    .cm_page(cm_page), .cm_in(cm_in), .ro_en(ro_en), .ro_sel(ro_sel),
    .ro_count(ro_count), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data),
`ifdef RO_SWEEP_PEAK_EN
    .peak_count(peak_count), .peak_tag(peak_tag),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // sweep model: expected results queue plus timing anchors
  bit          m_busy = 0, m_valid = 0, m_last = 0, exp_done = 0;
  int          m_ss = -1000, m_hs = -1000, start_cyc = 0, first_lat = -1;
  int          nres = 0, en_cycles = 0;
  logic [16:0] m_q[$];
  logic [5:0]  m_pat = '0;
  logic [16:0] first_data = '0, last_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_busy = 0;
    m_valid = 0;
    m_last = 0;
    m_q.delete();
  endtask

  task automatic model_and_check();
    int n;
    logic en_exp;
    cyc++;
    exp_done = 0;
    if (!rst_n || abort) begin
      model_clear();
    end else if (!m_busy) begin
      if (start) begin
        m_q.delete();
        n = int'(6'(page_last - page_first)) + 1;
        for (int i = 0; i < n; i++) begin
          for (int s = 0; s < 8; s++) begin
            logic [5:0] p;
            p = 6'(int'(page_first) + i);
            m_q.push_back({p, 3'(s), cnt_tab[p][s]});
          end
        end
        m_busy = 1; m_valid = 0; m_last = 0;
        m_ss = cyc; m_hs = -1000; start_cyc = cyc - 1;
        first_lat = -1; nres = 0; m_pat = pattern;
      end
    end else if (m_last) begin
      if (cyc == m_hs + 1) begin
        exp_done = 1;
        m_busy = 0;
      end
    end else if (m_valid && res_ready) begin
      last_data = m_q.pop_front();
      if (nres == 0) first_data = last_data;
      nres++;
      m_valid = 0;
      m_hs = cyc;
      if (m_q.size() == 0) m_last = 1;
      else m_ss = cyc + 1;
    end else if (!m_valid && cyc == m_ss + S + W + 1) begin
      m_valid = 1;
      if (first_lat < 0) first_lat = cyc - start_cyc;
    end

    en_exp = m_busy && (cyc >= m_ss + S) && (cyc < m_ss + S + W);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("ro_en", 32'(ro_en), 32'(en_exp));
    if (m_valid && m_q.size() > 0) chk("res_data", 32'(res_data), 32'(m_q[0]));
    if (m_busy && cyc != m_hs && m_q.size() > 0) begin
      chk("cm_page", 32'(cm_page), 32'(m_q[0][16:11]));
      chk("ro_sel", 32'(ro_sel), 32'(m_q[0][10:8]));
    end
    if (m_busy) chk("cm_in", 32'(cm_in), 32'(m_pat));
    if (ro_en) en_cycles++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_and_check();
  endtask

  task automatic do_start(input logic [5:0] f, input logic [5:0] l, input logic [5:0] p);
    page_first = f; page_last = l; pattern = p;
    start = 1'b1;
    tick();
    start = 1'b0;
    page_first = 6'h3F - f; page_last = 6'h3F - l; pattern = ~p;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && m_busy; i++) tick();
    chk("sweep_timeout", 32'(m_busy), 32'd0);
    tick();
  endtask

  task automatic fill_basic();
    for (int p = 0; p < 64; p++)
      for (int s = 0; s < 8; s++) cnt_tab[p][s] = 8'(10 + s);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cm_page"}, 32'(cm_page), 32'd0);
    chk({tag, "_cm_in"}, 32'(cm_in), 32'd0);
    chk({tag, "_ro_sel"}, 32'(ro_sel), 32'd0);
    chk({tag, "_ro_en"}, 32'(ro_en), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_data"}, 32'(res_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int en0, v_cyc;
    fill_basic();
    #1 check_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // basic single page
    do_start(6'd5, 6'd5, 6'h2A);
    wait_idle(400);
    chk("basic_nres", 32'(nres), 32'd8);
    chk("basic_latency", 32'(first_lat), 32'd22);
    chk("basic_first", 32'(first_data), 32'h280A);
    chk("basic_last", 32'(last_data), 32'h2F11);

    // wrapped range, with an ignored start mid-sweep
    for (int p = 0; p < 64; p++)
      for (int s = 0; s < 8; s++) cnt_tab[p][s] = 8'(p * 3 + s);
    en0 = en_cycles;
    do_start(6'd62, 6'd1, 6'h15);
    for (int i = 0; i < 30; i++) tick();
    page_first = 6'd20; page_last = 6'd20; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(2000);
    chk("wrap_nres", 32'(nres), 32'd32);
    chk("wrap_en_cycles", 32'(en_cycles - en0), 32'd512);
    chk("wrap_first", 32'(first_data), 32'h1F0BA);
    chk("wrap_last", 32'(last_data), 32'h0F0A);

    // backpressure on the third result
    fill_basic();
    do_start(6'd9, 6'd9, 6'h01);
    for (int i = 0; i < 200 && nres < 2; i++) tick();
    res_ready = 1'b0;
    for (int i = 0; i < 200 && !m_valid; i++) tick();
    chk("bp_valid_reached", 32'(m_valid), 32'd1);
    v_cyc = cyc;
    for (int i = 0; i < 10; i++) tick();
    res_ready = 1'b1;
    tick();
    chk("bp_hs_delay", 32'(m_hs - v_cyc), 32'd11);
    wait_idle(400);
    chk("bp_nres", 32'(nres), 32'd8);

    // abort mid-measure on page 3 tap 4, then a clean restart
    do_start(6'd2, 6'd4, 6'h0C);
    for (int i = 0; i < 800 && !(cm_page == 6'd3 && ro_sel == 3'd4 && ro_en); i++) tick();
    chk("abort_reached", 32'({cm_page, ro_sel, ro_en}), 32'({6'd3, 3'd4, 1'b1}));
    for (int i = 0; i < 5; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_page_kept", 32'(cm_page), 32'd3);
    chk("abort_sel_kept", 32'(ro_sel), 32'd4);
    chk("abort_in_kept", 32'(cm_in), 32'h0C);
    for (int i = 0; i < 5; i++) tick();
    do_start(6'd7, 6'd7, 6'h03);
    wait_idle(400);
    chk("post_abort_nres", 32'(nres), 32'd8);

    // start and abort together in idle
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    tick(); tick();

`ifdef RO_SWEEP_PEAK_EN
    cnt_tab[2][0] = 8'd7; cnt_tab[2][1] = 8'd9; cnt_tab[2][2] = 8'd9; cnt_tab[2][3] = 8'd3;
    for (int s = 4; s < 8; s++) cnt_tab[2][s] = 8'd1;
    do_start(6'd2, 6'd2, 6'h00);
    wait_idle(400);
    chk("peak_count", 32'(peak_count), 32'd9);
    chk("peak_tag", 32'(peak_tag), 32'h11);
    for (int s = 0; s < 8; s++) cnt_tab[6][s] = 8'd1;
    do_start(6'd6, 6'd6, 6'h00);
    wait_idle(400);
    chk("peak_count_cleared", 32'(peak_count), 32'd1);
    chk("peak_tag_cleared", 32'(peak_tag), 32'h30);
`endif

    // asynchronous reset while a result waits in EMIT
    res_ready = 1'b0;
    do_start(6'd12, 6'd12, 6'h05);
    for (int i = 0; i < 200 && !m_valid; i++) tick();
    chk("rst_valid_reached", 32'(res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
